// File: rtl/icache_fill.sv
`default_nettype none
// ============================================================================
// Module   : icache_fill
// Brief    : Direct-mapped instruction cache with a single-outstanding refill
//            FSM. Optional hit/miss counters enabled by ICACHE_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module icache_fill #(
    parameter int LINES = 16
) (
`ifdef ICACHE_PERF_CNT_EN
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt,
`endif
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic        ic_read_req,
    input  logic [29:0] ic_addr,
    output logic [63:0] ic_data,
    output logic        cache_stall,
    input  logic        inv,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata
);

    localparam int c_IDX_W = $clog2(LINES);
    localparam int c_TAG_W = 30 - c_IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t               r_state;
    logic [29:0]          r_miss_addr;
    logic [LINES-1:0]     r_valid;
    logic                 r_mem_req;
    logic [38:0]          r_data [LINES];
    logic [c_TAG_W-1:0]   r_tag  [LINES];

    logic [c_IDX_W-1:0]   w_idx;
    logic [c_TAG_W-1:0]   w_tag;
    logic [c_IDX_W-1:0]   w_fill_idx;
    logic                 w_hit;
    logic                 w_fill;
    logic                 w_unused;

    assign w_idx      = ic_addr[c_IDX_W-1:0];
    assign w_tag      = ic_addr[29:c_IDX_W];
    assign w_fill_idx = r_miss_addr[c_IDX_W-1:0];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill     = (r_state == ST_FETCH) && mem_ready && !rst;

    // Only the three 13-bit instructions are stored; upper bits read as zero.
    assign ic_data     = w_hit ? {25'd0, r_data[w_idx]} : 64'd0;
    assign cache_stall = fetch_valid && ((r_state != ST_IDLE) || !w_hit);
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_miss_addr;
    assign w_unused    = ^{ic_read_req, mem_rdata[63:39]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_miss_addr <= 30'd0;
            r_mem_req   <= 1'b0;
            r_valid     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (fetch_valid && !w_hit) begin
                        r_state     <= ST_FETCH;
                        r_miss_addr <= ic_addr;
                        r_mem_req   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
            // Invalidate has priority over a coincident refill install.
            if (inv) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[w_fill_idx] <= mem_rdata[38:0];
            r_tag[w_fill_idx]  <= r_miss_addr[29:c_IDX_W];
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= 16'd0;
            miss_cnt <= 16'd0;
        end else begin
            if (ic_read_req && w_hit && (r_state == ST_IDLE) && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if ((r_state == ST_IDLE) && fetch_valid && !w_hit && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
